// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver and colour-controller types
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    RECOVER
  } uart_state_t;

  typedef enum logic [1:0] {
    COL_RED,
    COL_GREEN,
    COL_BLUE
  } colour_sel_t;

  typedef logic [11:0] video_data_t;

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running oversample tick generator
module baud_tick_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counts 0..DIV-1 and wraps; the tick marks the last count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 oversampling UART receiver
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_error,
  output logic       busy
);

  // Start bit is confirmed at its middle; data/stop bits are sampled a full bit later each.
  localparam logic [3:0] MID_CNT  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

  logic        rx_meta;
  logic        rx_s;
  logic        tick;
  uart_state_t state, state_nx;
  logic [3:0]  sample_cnt, sample_cnt_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [7:0]  shift, shift_nx;
  logic [7:0]  rx_data_nx;
  logic        rx_ready_nx;
  logic        frame_error_nx;

  baud_tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      rx_data     <= '0;
      rx_ready    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nx;
      sample_cnt  <= sample_cnt_nx;
      bit_cnt     <= bit_cnt_nx;
      shift       <= shift_nx;
      rx_data     <= rx_data_nx;
      rx_ready    <= rx_ready_nx;
      frame_error <= frame_error_nx;
    end
  end

  // Next-state and datapath decisions for one frame.
  always_comb begin
    state_nx       = state;
    sample_cnt_nx  = sample_cnt;
    bit_cnt_nx     = bit_cnt;
    shift_nx       = shift;
    rx_data_nx     = rx_data;
    rx_ready_nx    = 1'b0;
    frame_error_nx = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx      = START;
          sample_cnt_nx = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sample_cnt == MID_CNT) begin
            sample_cnt_nx = '0;
            state_nx      = rx_s ? IDLE : DATA;
          end else begin
            sample_cnt_nx = sample_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sample_cnt == LAST_CNT) begin
            sample_cnt_nx = '0;
            shift_nx      = {rx_s, shift[7:1]};
            bit_cnt_nx    = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nx = STOP;
            end
          end else begin
            sample_cnt_nx = sample_cnt + 4'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (sample_cnt == LAST_CNT) begin
            sample_cnt_nx = '0;
            if (rx_s) begin
              rx_data_nx  = shift;
              rx_ready_nx = 1'b1;
              state_nx    = IDLE;
            end else begin
              frame_error_nx = 1'b1;
              state_nx       = RECOVER;
            end
          end else begin
            sample_cnt_nx = sample_cnt + 4'd1;
          end
        end
      end
      RECOVER: begin
        if (rx_s) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit period.
REQ-004 SHALL have port clock, input, 1, the single system clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idle high; 8N1 frames, LSB first.
REQ-007 SHALL have port rx_data, output, 8, last correctly framed byte; held until the next good frame.
REQ-008 SHALL have port rx_ready, output, 1, one-cycle pulse marking rx_data valid; feeds the colour-assembly controller directly.
REQ-009 SHALL have port frame_error, output, 1, one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer, with both flops resetting to 1; all logic uses the synchronized value rx_s.
REQ-012 SHALL generate a one-cycle tick every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clocks, using integer division (54 at defaults); the tick counter free-runs from 0 to DIV-1 and wraps.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, RECOVER.
REQ-014 IDLE: when rx_s is 0, SHALL go to START with sample counter cleared.
REQ-015 START: on tick, SHALL increment the sample counter; at count OVERSAMPLE/2-1 (7), if rx_s is 1 it SHALL return to IDLE (glitch rejection), else clear the counter and go to DATA.
REQ-016 DATA: SHALL sample rx_s every OVERSAMPLE ticks (counter = OVERSAMPLE-1, i.e. mid-bit) and shift it into bit 7 of the shift register, shifting right; after the 8th sample it SHALL go to STOP.
REQ-017 STOP: at the mid-bit sample, if rx_s is 1 it SHALL load rx_data from the shift register, pulse rx_ready in the same cycle, and go to IDLE.
REQ-018 STOP: at the mid-bit sample, if rx_s is 0 it SHALL pulse frame_error, leave rx_data unchanged, and go to RECOVER.
REQ-019 RECOVER: SHALL stay until rx_s is 1, then go to IDLE; a break (line held low) SHALL therefore produce exactly one frame_error.
REQ-020 rx_ready and frame_error SHALL never be high in the same cycle, and each SHALL be high for exactly one clock per frame.
REQ-021 Latency: rx_ready SHALL assert 9.5 bit periods ±1 tick after the synchronized falling edge of the start bit, plus the 2-cycle synchronizer delay.
REQ-022 A new start edge arriving in the same cycle rx_ready pulses SHALL be detected on the following cycle with no frame loss; back-to-back frames (1 stop bit, no gap) SHALL be received.
REQ-023 The sample counter SHALL be 4 bits wide and the bit counter 3 bits wide; counter wrap SHALL only occur where stated above.

Reset
REQ-024 On reset low, SHALL asynchronously force state=IDLE, rx_data=8'h00, rx_ready=0, frame_error=0, busy=0, all counters=0, shift register=0, and synchronizer flops=1.
REQ-025 If reset asserts mid-frame, SHALL discard the partial byte and produce no rx_ready or frame_error pulse; after release, reception SHALL resume at the next falling edge.

Structure
REQ-026 The state enum and the OVERSAMPLE default SHALL live in shared package uart_pkg, alongside the colour-controller types.
REQ-027 Tick generation SHALL be a separate sub-module, baud_tick_gen (params CLK_FREQ, BAUD_RATE, OVERSAMPLE; ports clock, reset, tick).
REQ-028 Everything else SHALL reside in uart_rx; there SHALL be no latches and no combinational path from rx to any output.

Verification
REQ-029 Send 8'hA5 at 115200 with 1 stop bit -> exactly one rx_ready pulse, rx_data=8'hA5, frame_error never high.
REQ-030 Send 8'hFF, 8'h80, 8'h0F back-to-back with no idle gap -> three rx_ready pulses; rx_data sequence FF, 80, 0F.
REQ-031 Drive a 3-tick low glitch on idle rx -> FSM returns to IDLE; no rx_ready, no frame_error; busy low again within 10 ticks.
REQ-032 Send 8'h3C with stop bit forced 0, then idle -> one frame_error pulse, no rx_ready, rx_data keeps its prior value; next good byte 8'h11 is received correctly.
REQ-033 Assert reset during data bit 4 of 8'hC3 and release 2 bit periods later -> all outputs zero, no pulse; following byte 8'h5A is received correctly.
REQ-034 Send three frames 8'hF0, 8'h80, 8'h40 into the colour-assembly controller -> 12-bit video data 12'hF84 with a single ready pulse.
